// File: rtl/lcd_up_pkg.sv
// Shared register map, status bits and state encodings for the lcd_module
// upstream pixel master.
package lcd_up_pkg;

    // lcd_module register addresses
    localparam int unsigned REG_CTRL  = 0;
    localparam int unsigned REG_STAT  = 1;
    localparam int unsigned REG_XY    = 2;
    localparam int unsigned REG_COLOR = 4;

    // REG_STAT bit positions
    localparam int unsigned STAT_INIT_BIT = 3;
    localparam int unsigned STAT_DONE_BIT = 4;

    // Pixel sequencing states
    typedef enum logic [2:0] {
        S_INIT_RD,
        S_INIT_WT,
        S_IDLE,
        S_XY,
        S_COL,
        S_GO,
        S_DONE_RD,
        S_DONE_WT
    } state_e;

    // Single-transaction engine states
    typedef enum logic [1:0] {
        X_IDLE,
        X_WR,
        X_RD
    } xact_e;

endpackage

// File: rtl/lcd_up_xact.sv
// Single up_* bus transaction engine: holds a write until acknowledged,
// pulses a read and samples the returned data, and aborts any wait that
// lasts TIMEOUT_CYC cycles. done/tout are one-cycle pulses.
module lcd_up_xact
    import lcd_up_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 12,
    parameter int TIMEOUT_CYC   = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic                     cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [31:0]              cmd_wdata,
    output logic                     cmd_ready,
    output logic                     done,
    output logic                     tout,
    output logic [31:0]              rdata,
    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);

    // Counter only needs to reach TIMEOUT_CYC-1 before the abort fires
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    xact_e                    st_q, st_d;
    logic [TW-1:0]            cnt_q, cnt_d;
    logic                     wreq_q, wreq_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     rreq_q, rreq_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     done_q, done_d;
    logic                     tout_q, tout_d;
    logic                     cnt_hit;

    // Refuse a new command during the done/tout pulse so the sequencer, which
    // still presents its old command in that cycle, cannot re-issue it. This
    // also guarantees an idle cycle between consecutive writes.
    assign cmd_ready = (st_q == X_IDLE) && !done_q && !tout_q;
    assign cnt_hit   = (cnt_q == TW'(TIMEOUT_CYC - 1));

    // Next-state: issue, wait for ack, or abort on timeout
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        wreq_d  = wreq_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rreq_d  = 1'b0;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        case (st_q)
            X_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_we) begin
                        wreq_d  = 1'b1;
                        waddr_d = cmd_addr;
                        wdata_d = cmd_wdata;
                        st_d    = X_WR;
                    end else begin
                        rreq_d  = 1'b1;
                        raddr_d = cmd_addr;
                        st_d    = X_RD;
                    end
                end
            end
            X_WR: begin
                if (up_wack) begin
                    wreq_d = 1'b0;
                    done_d = 1'b1;
                    cnt_d  = '0;
                    st_d   = X_IDLE;
                end else if (cnt_hit) begin
                    wreq_d = 1'b0;
                    tout_d = 1'b1;
                    cnt_d  = '0;
                    st_d   = X_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            X_RD: begin
                if (up_rack) begin
                    rdata_d = up_rdata;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    st_d    = X_IDLE;
                end else if (cnt_hit) begin
                    tout_d = 1'b1;
                    cnt_d  = '0;
                    st_d   = X_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                wreq_d = 1'b0;
                cnt_d  = '0;
                st_d   = X_IDLE;
            end
        endcase
    end

    // Engine registers; all bus outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= X_IDLE;
            cnt_q   <= '0;
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rreq_q  <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            wreq_q  <= wreq_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rreq_q  <= rreq_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign done     = done_q;
    assign tout     = tout_q;
    assign rdata    = rdata_q;
    assign up_wreq  = wreq_q;
    assign up_waddr = waddr_q;
    assign up_wdata = wdata_q;
    assign up_rreq  = rreq_q;
    assign up_raddr = raddr_q;

endmodule

// File: rtl/lcd_pixel_up_master.sv
// Upstream pixel feeder for lcd_module: turns a valid/ready (x, y, RGB565)
// stream into XY write, colour write, start write and a done poll, after
// first waiting for the panel to report initialisation complete.
module lcd_pixel_up_master
    import lcd_up_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 12,
    parameter logic [15:0] LCD_W_P       = 16'd128,
    parameter logic [15:0] LCD_H_P       = 16'd128,
    parameter int          TIMEOUT_CYC   = 65535
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [15:0]              pix_x,
    input  logic [15:0]              pix_y,
    input  logic [15:0]              pix_color,
    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack,
    input  logic                     err_clr,
    output logic                     lcd_ready,
    output logic                     busy,
    output logic [31:0]              pix_cnt,
    output logic [15:0]              drop_cnt,
    output logic                     err_timeout
);

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, col_q, col_d;
    logic        ready_q, ready_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        err_q, err_d;

    logic                     cmd_valid, cmd_we, cmd_ready;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [31:0]              cmd_wdata, x_rdata;
    logic                     x_done, x_tout;

    // Command presented to the engine, purely a function of the current state
    always_comb begin
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = ADDRESS_WIDTH'(REG_STAT);
        cmd_wdata = '0;
        case (state_q)
            S_INIT_RD, S_DONE_RD: cmd_valid = 1'b1;
            S_XY: begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = ADDRESS_WIDTH'(REG_XY);
                cmd_wdata = {x_q, y_q};
            end
            S_COL: begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = ADDRESS_WIDTH'(REG_COLOR);
                cmd_wdata = {16'd0, col_q};
            end
            S_GO: begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = ADDRESS_WIDTH'(REG_CTRL);
                cmd_wdata = 32'd1;
            end
            default: ;
        endcase
    end

    // Sequencer next-state, pixel latching and counters
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        col_d      = col_q;
        ready_d    = ready_q;
        pix_cnt_d  = pix_cnt_q;
        drop_cnt_d = drop_cnt_q;
        // a timeout in the same cycle as err_clr leaves the flag set
        err_d      = (err_q & ~err_clr) | x_tout;
        if (x_tout) begin
            ready_d = 1'b0;
            state_d = S_INIT_RD;
        end else begin
            case (state_q)
                S_INIT_RD: if (cmd_ready) state_d = S_INIT_WT;
                S_INIT_WT: begin
                    if (x_done) begin
                        if (x_rdata[STAT_INIT_BIT]) begin
                            ready_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_INIT_RD;
                        end
                    end
                end
                S_IDLE: begin
                    if (pix_valid) begin
                        x_d   = pix_x;
                        y_d   = pix_y;
                        col_d = pix_color;
                        if (pix_x >= LCD_W_P || pix_y >= LCD_H_P) begin
                            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                        end else begin
                            state_d = S_XY;
                        end
                    end
                end
                S_XY:      if (x_done) state_d = S_COL;
                S_COL:     if (x_done) state_d = S_GO;
                S_GO:      if (x_done) state_d = S_DONE_RD;
                S_DONE_RD: if (cmd_ready) state_d = S_DONE_WT;
                S_DONE_WT: begin
                    if (x_done) begin
                        if (x_rdata[STAT_DONE_BIT]) begin
                            pix_cnt_d = pix_cnt_q + 32'd1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_DONE_RD;
                        end
                    end
                end
                default: state_d = S_INIT_RD;
            endcase
        end
    end

    // Sequencer registers
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q    <= S_INIT_RD;
            x_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
            ready_q    <= 1'b0;
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
            ready_q    <= ready_d;
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    lcd_up_xact #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .TIMEOUT_CYC   (TIMEOUT_CYC)
    ) u_xact (
        .clk       (up_clk),
        .rst_n     (up_rstn),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_ready (cmd_ready),
        .done      (x_done),
        .tout      (x_tout),
        .rdata     (x_rdata),
        .up_wreq   (up_wreq),
        .up_waddr  (up_waddr),
        .up_wdata  (up_wdata),
        .up_wack   (up_wack),
        .up_rreq   (up_rreq),
        .up_raddr  (up_raddr),
        .up_rdata  (up_rdata),
        .up_rack   (up_rack)
    );

    assign pix_ready   = (state_q == S_IDLE);
    assign busy        = (state_q == S_XY)      || (state_q == S_COL) ||
                         (state_q == S_GO)      || (state_q == S_DONE_RD) ||
                         (state_q == S_DONE_WT);
    assign lcd_ready   = ready_q;
    assign pix_cnt     = pix_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_lcd_pixel_up_master.sv
// Bench for lcd_pixel_up_master: a reactive lcd_module stub answers the
// up_* bus; expected register writes are queued per pixel and compared
// against the writes the stub actually accepted.
module tb_lcd_pixel_up_master;
    import lcd_up_pkg::*;

    localparam int AW = 12;
    localparam int TO = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          up_clk = 1'b0;
    logic          up_rstn = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [15:0]   pix_x = '0, pix_y = '0, pix_color = '0;
    logic          up_wreq;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_rreq;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;
    logic          err_clr = 1'b0;
    logic          lcd_ready, busy, err_timeout;
    logic [31:0]   pix_cnt;
    logic [15:0]   drop_cnt;

    int errors = 0;
    int checks = 0;

    // stub configuration (written by tests) and stub state (written by stub)
    int  init_cfg = 5, done_init_cfg = 1, done_n = 2;
    bit  wack_rand = 1'b0, block_col = 1'b0;
    int  init_left, done_left, wdly, rdly;
    bit  rd_pend;
    int  wr_cnt = 0, rreq_cnt = 0, rack_cnt = 0, overlap_cnt = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    always #5 up_clk = ~up_clk;

    lcd_pixel_up_master #(
        .ADDRESS_WIDTH (AW),
        .LCD_W_P       (16'd128),
        .LCD_H_P       (16'd128),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .up_clk      (up_clk),
        .up_rstn     (up_rstn),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .up_wreq     (up_wreq),
        .up_waddr    (up_waddr),
        .up_wdata    (up_wdata),
        .up_wack     (up_wack),
        .up_rreq     (up_rreq),
        .up_raddr    (up_raddr),
        .up_rdata    (up_rdata),
        .up_rack     (up_rack),
        .err_clr     (err_clr),
        .lcd_ready   (lcd_ready),
        .busy        (busy),
        .pix_cnt     (pix_cnt),
        .drop_cnt    (drop_cnt),
        .err_timeout (err_timeout)
    );

    // lcd_module stub: acks writes after 0..3 cycles, answers status reads
    always @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_wack   <= 1'b0;
            up_rack   <= 1'b0;
            up_rdata  <= '0;
            rd_pend   = 1'b0;
            wdly      = 0;
            rdly      = 0;
            init_left = init_cfg;
            done_left = done_init_cfg;
        end else begin
            if (up_wreq && up_wack) begin
                obs_q.push_back({up_waddr, up_wdata});
                wr_cnt++;
                if (up_waddr == 12'(REG_CTRL)) done_left = done_n;
                up_wack <= 1'b0;
                wdly = wack_rand ? int'($urandom_range(0, 3)) : 0;
            end else if (up_wreq && !(block_col && up_waddr == 12'(REG_COLOR))) begin
                if (wdly == 0) up_wack <= 1'b1;
                else wdly--;
            end else begin
                up_wack <= 1'b0;
            end

            up_rack <= 1'b0;
            if (up_rreq) begin
                rd_pend = 1'b1;
                rdly    = int'($urandom_range(0, 2));
                rreq_cnt++;
            end else if (rd_pend) begin
                if (rdly == 0) begin
                    rd_pend = 1'b0;
                    up_rack <= 1'b1;
                    rack_cnt++;
                    if (init_left > 0) begin
                        up_rdata <= 32'h0;
                        init_left--;
                    end else if (done_left > 0) begin
                        up_rdata <= 32'h8;
                        done_left--;
                    end else begin
                        up_rdata <= 32'h18;
                    end
                end else begin
                    rdly--;
                end
            end
        end
    end

    // write and read requests must never be on the bus together
    always @(negedge up_clk) if (up_wreq && up_rreq) overlap_cnt++;

    function automatic wr_t mk(input int unsigned a, input logic [31:0] d);
        return {12'(a), d};
    endfunction

    // offer one pixel and hold it until accepted
    task automatic send_pix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
        int n = 0;
        @(negedge up_clk);
        pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
        while (!pix_ready && n < 500) begin
            @(negedge up_clk);
            n++;
        end
        if (!pix_ready) begin
            checks++; errors++;
            $display("FAIL send_pix_accept: pix_ready=%0b required 1", pix_ready);
        end
        @(posedge up_clk);
        #1 pix_valid = 1'b0;
    endtask

    task automatic wait_pix_cnt(input int target, input int bound);
        int n = 0;
        while (pix_cnt != 32'(target) && n < bound) begin
            @(negedge up_clk);
            n++;
        end
        if (pix_cnt != 32'(target)) begin
            checks++; errors++;
            $display("FAIL wait_pix_cnt: pix_cnt=%0d required %0d", pix_cnt, target);
        end
    endtask

    task automatic test_reset();
        up_rstn = 1'b0;
        repeat (3) @(negedge up_clk);
        checks++;
        if ({pix_ready, up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, lcd_ready,
             busy, pix_cnt, drop_cnt, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wreq=%0b rreq=%0b ready=%0b pix_ready=%0b cnt=%0d required all 0",
                     up_wreq, up_rreq, lcd_ready, pix_ready, pix_cnt);
        end
    endtask

    task automatic test_init();
        int  n = 0;
        bit  early = 1'b0, seen_rd = 1'b0;
        logic [AW-1:0] ra = '0;
        up_rstn = 1'b1;
        while (!lcd_ready && n < 300) begin
            @(negedge up_clk);
            if (pix_ready && !lcd_ready) early = 1'b1;
            if (up_rreq && !seen_rd) begin seen_rd = 1'b1; ra = up_raddr; end
            n++;
        end
        checks++;
        if (lcd_ready !== 1'b1) begin errors++; $display("FAIL init_ready: lcd_ready=%0b required 1", lcd_ready); end
        checks++;
        if (rack_cnt != 6) begin errors++; $display("FAIL init_rack_count: racks=%0d required 6", rack_cnt); end
        checks++;
        if (early) begin errors++; $display("FAIL init_pix_ready_early: pix_ready=1 before lcd_ready, required 0"); end
        checks++;
        if (ra !== 12'(REG_STAT)) begin errors++; $display("FAIL init_raddr: raddr=%0d required %0d", ra, REG_STAT); end
        checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL init_idle: pix_ready=%0b busy=%0b required 1/0", pix_ready, busy);
        end
    endtask

    task automatic test_single();
        wr_t e, o;
        exp_q.push_back(mk(REG_XY, 32'h0005_0007));
        exp_q.push_back(mk(REG_COLOR, 32'h0000_F800));
        exp_q.push_back(mk(REG_CTRL, 32'h1));
        send_pix(16'd5, 16'd7, 16'hF800);
        wait_pix_cnt(1, 300);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_write: got %h/%h required %h/%h", o.addr, o.data, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
        @(negedge up_clk);
        checks++;
        if (pix_cnt !== 32'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_cnt: pix_cnt=%0d busy=%0b required 1/0", pix_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        logic [15:0] c;
        int bad = 0;
        wack_rand = 1'b1;
        for (int i = 0; i < 128; i++) begin
            c = 16'(i * 16'h0123 + 16'h0F0F);
            done_n = int'($urandom_range(0, 2));
            exp_q.push_back(mk(REG_XY, {16'(i), 16'd0}));
            exp_q.push_back(mk(REG_COLOR, {16'd0, c}));
            exp_q.push_back(mk(REG_CTRL, 32'h1));
            send_pix(16'(i), 16'd0, c);
        end
        wait_pix_cnt(129, 6000);
        wack_rand = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stream_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                if (bad++ < 5) $display("FAIL stream_write: got %h/%h required %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (pix_cnt !== 32'd129) begin errors++; $display("FAIL stream_cnt: pix_cnt=%0d required 129", pix_cnt); end
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL stream_overlap: wreq&rreq cycles=%0d required 0", overlap_cnt); end
    endtask

    task automatic test_out_of_range();
        int w0 = wr_cnt, r0 = rreq_cnt;
        send_pix(16'd128, 16'd0, 16'h1111);
        repeat (6) @(negedge up_clk);
        checks++;
        if (drop_cnt !== 16'd1) begin errors++; $display("FAIL oor_x_drop: drop_cnt=%0d required 1", drop_cnt); end
        checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL oor_ready: pix_ready=%0b busy=%0b required 1/0", pix_ready, busy);
        end
        checks++;
        if (wr_cnt != w0 || rreq_cnt != r0) begin
            errors++; $display("FAIL oor_bus: writes=%0d reads=%0d required %0d/%0d", wr_cnt, rreq_cnt, w0, r0);
        end
        send_pix(16'd0, 16'd128, 16'h2222);
        send_pix(16'hFFFF, 16'hFFFF, 16'h3333);
        repeat (3) @(negedge up_clk);
        checks++;
        if (drop_cnt !== 16'd3 || wr_cnt != w0 || pix_cnt !== 32'd129) begin
            errors++; $display("FAIL oor_y_drop: drop_cnt=%0d writes=%0d pix_cnt=%0d required 3/%0d/129", drop_cnt, wr_cnt, pix_cnt, w0);
        end
    endtask

    task automatic test_timeout();
        wr_t e, o;
        int ncol = 0, n = 0;
        block_col = 1'b1;
        exp_q.push_back(mk(REG_XY, 32'h0001_0001));
        send_pix(16'd1, 16'd1, 16'h1234);
        while (!err_timeout && n < 100) begin
            @(negedge up_clk);
            if (up_wreq && up_waddr == 12'(REG_COLOR)) ncol++;
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: err_timeout=%0b required 1", err_timeout); end
        checks++;
        if (ncol != TO) begin errors++; $display("FAIL to_wait_cycles: colour wreq cycles=%0d required %0d", ncol, TO); end
        checks++;
        if (lcd_ready !== 1'b0 || busy !== 1'b0 || up_wreq !== 1'b0 || pix_cnt !== 32'd129) begin
            errors++; $display("FAIL to_abort: ready=%0b busy=%0b wreq=%0b pix_cnt=%0d required 0/0/0/129",
                               lcd_ready, busy, up_wreq, pix_cnt);
        end
        block_col = 1'b0;
        n = 0;
        while (!lcd_ready && n < 100) begin @(negedge up_clk); n++; end
        checks++;
        if (lcd_ready !== 1'b1 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL to_reinit: lcd_ready=%0b err_timeout=%0b required 1/1", lcd_ready, err_timeout);
        end
        err_clr = 1'b1;
        @(negedge up_clk);
        err_clr = 1'b0;
        @(negedge up_clk);
        checks++;
        if (err_timeout !== 1'b0 || pix_cnt !== 32'd129) begin
            errors++; $display("FAIL to_clear: err_timeout=%0b pix_cnt=%0d required 0/129", err_timeout, pix_cnt);
        end
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL to_nwrites: got %0d required 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL to_xy_write: got %h/%h required %h/%h", o.addr, o.data, e.addr, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midop();
        int w0 = wr_cnt, n = 0, r0;
        done_n = 50;
        send_pix(16'd2, 16'd3, 16'h07E0);
        while (wr_cnt < w0 + 3 && n < 200) begin @(negedge up_clk); n++; end
        n = 0;
        while (!up_rreq && n < 50) begin @(negedge up_clk); n++; end
        @(negedge up_clk);
        checks++;
        if (busy !== 1'b1 || wr_cnt != w0 + 3) begin
            errors++; $display("FAIL mid_setup: busy=%0b writes=%0d required 1/%0d", busy, wr_cnt, w0 + 3);
        end
        init_cfg = 2; done_init_cfg = 0; done_n = 0;
        up_rstn = 1'b0;
        #1;
        checks++;
        if ({pix_ready, up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, lcd_ready,
             busy, pix_cnt, drop_cnt, err_timeout} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%0b ready=%0b pix_cnt=%0d drop_cnt=%0d required all 0",
                     busy, lcd_ready, pix_cnt, drop_cnt);
        end
        obs_q.delete(); exp_q.delete();
        repeat (2) @(negedge up_clk);
        r0 = rack_cnt;
        up_rstn = 1'b1;
        n = 0;
        while (!lcd_ready && n < 200) begin @(negedge up_clk); n++; end
        checks++;
        if (lcd_ready !== 1'b1 || rack_cnt - r0 != 3 || pix_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reinit: lcd_ready=%0b racks=%0d pix_cnt=%0d required 1/3/0",
                               lcd_ready, rack_cnt - r0, pix_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_timeout();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_up_master.md
Name: lcd_pixel_up_master

Overview:
- Upstream feeder for lcd_module. Accepts a valid/ready pixel stream of (x, y, RGB565 colour) and converts each pixel into the register transactions lcd_module expects on its up_* bus: coordinate write, colour write, start write, then completion poll.
- Replaces ad-hoc per-top drawing FSMs, so pattern generators and framebuffer readers can simply stream pixels.

Parameters:
- ADDRESS_WIDTH, 12: width of up_waddr/up_raddr.
- LCD_W_P, 16'd128: panel width in pixels; valid x is 0..LCD_W_P-1.
- LCD_H_P, 16'd128: panel height in pixels; valid y is 0..LCD_H_P-1.
- TIMEOUT_CYC, 65535: maximum cycles spent in any single wait state (ack or status poll) before abort.

Ports:
- up_clk  in  1  sole clock.
- up_rstn  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready are both high.
- pix_x  in  16  column.
- pix_y  in  16  row.
- pix_color  in  16  RGB565 colour.
- up_wreq  out  1  write request to lcd_module.
- up_waddr  out  ADDRESS_WIDTH  write address.
- up_wdata  out  32  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  read request.
- up_raddr  out  ADDRESS_WIDTH  read address.
- up_rdata  in  32  read data; valid when up_rack is high.
- up_rack  in  1  read acknowledge.
- err_clr  in  1  clears the sticky error flags.
- lcd_ready  out  1  panel initialisation seen complete.
- busy  out  1  a pixel transaction is in flight.
- pix_cnt  out  32  pixels completed; wraps at 2^32.
- drop_cnt  out  16  out-of-range pixels dropped; saturates at 16'hFFFF.
- err_timeout  out  1  sticky.

Behaviour:
- Reset (async, up_rstn=0): all outputs 0; up_waddr, up_raddr and up_wdata 0; state S_INIT_RD; timeout counter 0.
- Register map (package constants): REG_CTRL=0 (write 1 = start), REG_STAT=1 (bit3 = init done, bit4 = pixel done), REG_XY=2 ({x[15:0], y[15:0]}), REG_COLOR=4 ({16'd0, color}).
- Read rule:
  - up_rreq is a 1-cycle pulse with up_raddr=REG_STAT.
  - Wait for up_rack, then sample up_rdata in that cycle.
  - If the tested bit is 0, idle one cycle, then pulse again.
- Write rule:
  - Assert up_wreq with stable addr/data and hold it until the first cycle up_wack=1.
  - Deassert up_wreq the following cycle.
  - The next write may not start earlier than one cycle after deassertion.
- State machine:
  - S_INIT_RD/S_INIT_WT: poll REG_STAT bit3. When set: lcd_ready<=1, go to S_IDLE. lcd_ready then stays 1 until reset or timeout.
  - S_IDLE: pix_ready=1 (combinational from state; the only state with pix_ready high). On accept, latch x, y and colour.
    - If x>=LCD_W_P or y>=LCD_H_P: drop the pixel, drop_cnt+1, stay in S_IDLE.
    - Otherwise go to S_XY.
  - S_XY: write REG_XY.
  - S_COL: write REG_COLOR.
  - S_GO: write REG_CTRL with data 32'd1.
  - S_DONE_RD/S_DONE_WT: poll REG_STAT bit4. When set: pix_cnt+1, return to S_IDLE.
- busy=1 in S_XY through S_DONE_WT.
- Minimum per-pixel cost is 3 writes plus 1 read. The next pixel may be accepted in the cycle S_IDLE is re-entered.
- Timeout:
  - The counter resets on every state change and increments on every cycle spent in a wait.
  - On reaching TIMEOUT_CYC: err_timeout<=1, drop up_wreq/up_rreq, lcd_ready<=0, go to S_INIT_RD. The in-flight pixel is lost and not counted.
- err_clr clears err_timeout only; the error flag wins if it is set and cleared in the same cycle.
- pix_valid while not in S_IDLE: ignored (pix_ready=0); the upstream source must hold the pixel.
- up_rack arriving with no outstanding read, or up_wack with no outstanding write: ignored.

Decomposition:
- Package lcd_up_pkg: REG_CTRL, REG_STAT, REG_XY, REG_COLOR, STAT_INIT_BIT=3, STAT_DONE_BIT=4, and the state enumeration.
- One natural sub-module, lcd_up_xact: single-transaction engine (write hold-until-ack, read pulse/sample, timeout counter) with a cmd/done/rdata interface. The top keeps the sequencing FSM and the counters.

Test Plan:
- Init: stub returns stat=0 for 5 reads, then 32'h8 -> lcd_ready rises only after the 6th rack; pix_ready stays 0 until then.
- Single pixel (x=5, y=7, color=16'hF800): writes seen in order addr2/32'h00050007, addr4/32'h0000F800, addr0/32'h1; polls until bit4=1; pix_cnt=1.
- Back-to-back stream of 128 pixels (x=0..127, y=0), stub wack delay 0..3 random: every xy/color pair is correct; pix_cnt=128; up_wreq never overlaps up_rreq.
- Out-of-range: x=128, y=0 -> no up_* activity; drop_cnt=1; pix_ready remains 1.
- Timeout: TIMEOUT_CYC=16, stub never asserts wack in S_COL -> err_timeout=1 after 16 cycles; state returns to init poll; pix_cnt unchanged; err_clr clears the flag.
- Reset mid-op: drop up_rstn during S_DONE_WT -> all outputs 0 immediately; after release, the init poll restarts.
